pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised inter-stage pipeline register with a valid/ready handshake and a one-entry skid buffer, replacing plain write-enabled registers between processor stages. Stalls from downstream do not propagate combinationally upstream: `in_ready` is driven only from state flops. A synchronous `flush` squashes in-flight contents for branch and exception recovery. The block sustains one transfer per cycle, in order, with no loss or duplication.

## Interface
- `WIDTH`, 64, payload width in bits (≥1)
- `RESET_VAL`, '0, value loaded into both data registers on reset
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears the block immediately
- `in_valid`  in  1  upstream presents `in_data`
- `in_ready`  out  1  block can accept; registered, no comb path from `out_ready`
- `in_data`  in  WIDTH  upstream payload
- `out_valid`  out  1  `out_data` holds a valid entry
- `out_ready`  in  1  downstream takes `out_data` this cycle
- `out_data`  out  WIDTH  head entry (main register)
- `flush`  in  1  synchronous squash of all entries
- `count`  out  2  occupancy: 0, 1 or 2

## Operation
- accept = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- States: EMPTY (0 entries), HALF (main valid), FULL (main + skid valid).
- Outputs decode from state: `in_ready` = (state != FULL); `out_valid` = (state != EMPTY); `count` = 0/1/2; `out_data` = main.
- EMPTY: accept → HALF, main ← `in_data`.
- HALF: accept & pop → HALF, main ← `in_data`; accept & !pop → FULL, skid ← `in_data`; !accept & pop → EMPTY; neither → hold.
- FULL: pop → HALF, main ← skid; no pop → hold. No accept occurs because `in_ready`=0.
- `flush`=1 has highest priority. Next state is EMPTY, and any accept or pop in the same cycle is discarded. Data registers hold their values.
- `out_data` is unspecified when `out_valid`=0. The bench checks it only under `out_valid`.
- Data registers load only on the transitions listed above and otherwise hold.

## Timing
- Reset asserted (0): state goes EMPTY asynchronously. `out_valid`=0, `count`=0, `in_ready`=1, main = skid = `RESET_VAL`. Handshakes during reset are ignored.
- First edge after reset deasserts is a normal cycle.
- Reset mid-operation: all entries are lost immediately, with no partial transfer.
- Latency: an entry accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N (1 cycle).
- Throughput: 1 entry/cycle while `out_ready`=1 continuously.
- When `out_ready` drops for one cycle with a continuous input stream, the skid entry absorbs the in-flight word. `in_ready` falls one cycle later and rises the cycle after the next pop.
- `flush` and `reset` together: reset dominates.

## Structure
- Package `pipe_pkg` holds `typedef enum logic [1:0] {PS_EMPTY, PS_HALF, PS_FULL} pipe_state_t` and the occupancy constants.
- Sub-module `en_reg #(WIDTH, RESET_VAL)`: enabled register with asynchronous active-low reset. It is instantiated twice, once for main and once for skid.
- The main register's input mux selects `in_data` or skid.
- The state register and next-state logic live in the top module.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, release → `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=`RESET_VAL`.
- Streaming: `out_ready`=1, send 0x11,0x22,0x33 on consecutive cycles → each appears one cycle later in order; `count` stays 1; `in_ready` stays 1.
- Skid capture: stream 0xA1,0xA2,0xA3, drop `out_ready` for the cycle 0xA1 is at the head → `count`=2, `in_ready`=0 for one cycle; output sequence is 0xA1,0xA2,0xA3 with no loss or duplication.
- Backpressure hold: fill with 0x5A,0xC3, keep `out_ready`=0 for 5 cycles with `in_valid`=1 and `in_data`=0xFF → state FULL, `out_data`=0x5A throughout, 0xFF never accepted.
- Flush: in FULL (0x01,0x02), assert `flush` together with `in_valid` (0x03) and `out_ready` → next cycle `count`=0, `out_valid`=0; 0x01–0x03 never appear at the output.
- Async reset mid-stream: in HALF, pull `reset` low between edges → `out_valid` and `count` clear before the next edge; after release, fresh data 0x7E passes with 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_HALF  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Occupancy is a pure decode of the state; an unused encoding reads as empty.
  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      PS_HALF: occ_of = OCC_HALF;
      PS_FULL: occ_of = OCC_FULL;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/en_reg.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module en_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a one-entry skid buffer. in_ready is a
// pure state decode, so downstream stalls never reach upstream combinationally.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  pipe_state_t      state, state_nxt;
  logic             accept, pop;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign in_ready  = (state != PS_FULL);
  assign out_valid = (state != PS_EMPTY);
  assign count     = occ_of(state);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // State register; reset empties the block immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PS_EMPTY;
    else        state <= state_nxt;
  end

  // Next state and register enables. Flush discards any handshake this cycle
  // and leaves the data registers untouched.
  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    if (flush) begin
      state_nxt = PS_EMPTY;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (accept) begin
            state_nxt = PS_HALF;
            main_en   = 1'b1;
          end
        end
        PS_HALF: begin
          if (accept && pop) begin
            main_en = 1'b1;
          end else if (accept) begin
            state_nxt = PS_FULL;
            skid_en   = 1'b1;
          end else if (pop) begin
            state_nxt = PS_EMPTY;
          end
        end
        PS_FULL: begin
          // in_ready is low here, so only a pop can move things.
          if (pop) begin
            state_nxt = PS_HALF;
            main_en   = 1'b1;
          end
        end
        default: state_nxt = PS_EMPTY;
      endcase
    end
  end

  // Main refills from the skid only when draining out of FULL.
  assign main_d = (state == PS_FULL) ? skid_q : in_data;

  en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .rst_n (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: stimulus pushes the expected output
// stream into a queue, a negedge monitor pops and compares on every transfer.
module tb_pipe_skid_reg;

  localparam int             W    = 8;
  localparam logic [W-1:0]   RVAL = 8'hE5;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_data;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [1:0]   count;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every real transfer must match the head of the expected stream.
  always @(negedge clk) begin
    if (reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h, expected no transfer", out_data);
      end else begin
        check("out_data", {56'd0, out_data}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset then idle
    step(); step();
    reset = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_data",  64'(out_data),  64'(RVAL));
    step();

    // Streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'h11; exp_q.push_back(8'h11); step();
    check("stream_count1", 64'(count), 64'd1);
    check("stream_out_data1", 64'(out_data), 64'h11);
    in_data = 8'h22; exp_q.push_back(8'h22); step();
    check("stream_count2", 64'(count), 64'd1);
    check("stream_in_ready2", 64'(in_ready), 64'd1);
    in_data = 8'h33; exp_q.push_back(8'h33); step();
    check("stream_count3", 64'(count), 64'd1);
    in_valid = 1'b0; step();
    check("stream_drain_count", 64'(count), 64'd0);

    // Skid capture
    in_valid = 1'b1; in_data = 8'hA1;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    step();
    out_ready = 1'b0; in_data = 8'hA2; step();
    check("skid_count_full", 64'(count), 64'd2);
    check("skid_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1; in_data = 8'hA3; step();
    check("skid_count_half", 64'(count), 64'd1);
    check("skid_in_ready_high", 64'(in_ready), 64'd1);
    check("skid_head_a2", 64'(out_data), 64'hA2);
    step();
    check("skid_head_a3", 64'(out_data), 64'hA3);
    in_valid = 1'b0; step();
    check("skid_drain_count", 64'(count), 64'd0);

    // Backpressure hold
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h5A; exp_q.push_back(8'h5A); step();
    in_data = 8'hC3; exp_q.push_back(8'hC3); step();
    in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      check("bp_count", 64'(count), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_data", 64'(out_data), 64'h5A);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; step();
    check("bp_head_c3", 64'(out_data), 64'hC3);
    step();
    check("bp_drain_count", 64'(count), 64'd0);

    // Flush from FULL with simultaneous accept and pop
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h01; step();
    in_data = 8'h02; step();
    check("flush_pre_count", 64'(count), 64'd2);
    flush = 1'b1; in_data = 8'h03; out_ready = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    step(); step();
    check("flush_stays_empty", 64'(count), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C; step();
    in_valid = 1'b0;
    check("arst_pre_count", 64'(count), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    step();
    reset = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h7E; exp_q.push_back(8'h7E); step();
    in_valid = 1'b0;
    check("arst_fresh_valid", 64'(out_valid), 64'd1);
    check("arst_fresh_data", 64'(out_data), 64'h7E);
    step(); step();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
